// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch PC unit and its return-address stack.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_RAS,
    SEL_BR,
    SEL_JALR,
    SEL_TRAP
  } pc_sel_e;

  // Pointer width for a stack of `depth` entries; depth is a power of two >= 2.
  function automatic int ras_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Bundle of the fetch-PC control and result signals, for environments that drive pc_unit.
interface pc_unit_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  enable;
  logic                  FlushTrap;
  logic [DATA_WIDTH-1:0] TrapVector;
  logic                  PCSrcE;
  logic [DATA_WIDTH-1:0] PCTargetE;
  logic                  JALRinstr;
  logic [DATA_WIDTH-1:0] ALUResultE;
  logic                  CallF;
  logic                  RetF;
  logic                  HalfF;
  logic [DATA_WIDTH-1:0] PCF;
  logic [DATA_WIDTH-1:0] PCPlus4F;
  logic                  RasHitF;
  logic                  MisalignE;

  modport master (
    output enable, FlushTrap, TrapVector, PCSrcE, PCTargetE, JALRinstr, ALUResultE,
           CallF, RetF, HalfF,
    input  PCF, PCPlus4F, RasHitF, MisalignE
  );

  modport slave (
    input  enable, FlushTrap, TrapVector, PCSrcE, PCTargetE, JALRinstr, ALUResultE,
           CallF, RetF, HalfF,
    output PCF, PCPlus4F, RasHitF, MisalignE
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry,
// a pop on empty is ignored, push+pop together replaces the top in place.
module pc_ras
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] top,
  output logic                  empty
);

  localparam int              PW       = ras_ptr_w(RAS_DEPTH);
  localparam logic [PW:0]     CNT_FULL = (PW + 1)'(RAS_DEPTH);
  localparam logic [PW:0]     CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

  logic [DATA_WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]         ptr_q, ptr_d;   // next free slot
  logic [PW:0]           cnt_q, cnt_d;
  logic [PW-1:0]         top_idx;
  logic [PW-1:0]         wr_idx;
  logic                  wr_en;
  logic                  pop_ok;

  assign top_idx = ptr_q - PTR_ONE;
  assign empty   = (cnt_q == '0);
  assign top     = mem_q[top_idx];
  assign pop_ok  = pop & ~empty;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (clear) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (push && pop_ok) begin
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + PTR_ONE;
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_ONE;
    end else if (pop_ok) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: entries are never read while the count says empty, so the storage
  // carries no reset and can map onto plain flops or a register file.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter: prioritised next-PC selection (trap, JALR, branch,
// return-address prediction, sequential) with stall and misalignment hold.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    RAS_DEPTH    = 4,
  parameter int                    C_EXT        = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  FlushTrap,
  input  logic [DATA_WIDTH-1:0] TrapVector,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  input  logic                  JALRinstr,
  input  logic [DATA_WIDTH-1:0] ALUResultE,
  input  logic                  CallF,
  input  logic                  RetF,
  input  logic                  HalfF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  RasHitF,
  output logic                  MisalignE
);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] jalr_tgt;
  logic [DATA_WIDTH-1:0] exe_tgt;
  logic [DATA_WIDTH-1:0] ras_top;
  logic                  ras_empty;
  logic                  exe_redirect;
  logic                  ras_ok;
  logic                  pc_en;
  pc_sel_e               sel;

  assign PCF      = pc_q;
  assign PCPlus4F = pc_q + (((C_EXT != 0) && HalfF) ? DATA_WIDTH'(2) : DATA_WIDTH'(4));

  assign jalr_tgt     = ALUResultE & ~DATA_WIDTH'(1);
  assign exe_redirect = JALRinstr | PCSrcE;
  assign exe_tgt      = JALRinstr ? jalr_tgt : PCTargetE;
  // Without 16-bit instructions a target with bit 1 set cannot be fetched;
  // hold the PC and let the trap unit redirect.
  assign MisalignE    = (C_EXT == 0) && exe_redirect && exe_tgt[1];

  // NOTE: combinational blocks assign every output a default first so no
  // path through the if/case chain leaves a latch behind.
  always_comb begin
    sel = SEL_SEQ;
    if (FlushTrap)                  sel = SEL_TRAP;
    else if (JALRinstr)             sel = SEL_JALR;
    else if (PCSrcE)                sel = SEL_BR;
    else if (RetF && !ras_empty)    sel = SEL_RAS;
  end

  always_comb begin
    pc_d = PCPlus4F;
    unique case (sel)
      SEL_TRAP: pc_d = TrapVector;
      SEL_JALR: pc_d = jalr_tgt;
      SEL_BR:   pc_d = PCTargetE;
      SEL_RAS:  pc_d = ras_top;
      default:  pc_d = PCPlus4F;
    endcase
  end

  assign RasHitF = (sel == SEL_RAS);
  assign pc_en   = FlushTrap || (enable && !MisalignE);
  assign ras_ok  = enable && !FlushTrap && !exe_redirect;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   pc_q <= RESET_VECTOR;
    else if (pc_en) pc_q <= pc_d;
  end

  pc_ras #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAS_DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (FlushTrap),
    .push      (CallF && ras_ok),
    .pop       (RetF && ras_ok),
    .push_data (PCPlus4F),
    .top       (ras_top),
    .empty     (ras_empty)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expected values queued as stimulus is applied,
// popped and asserted when the DUT output is sampled.
module tb_pc_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  pc_unit_if #(.DATA_WIDTH(W)) b0 ();
  pc_unit_if #(.DATA_WIDTH(W)) b1 ();

  pc_unit #(.DATA_WIDTH(W), .RESET_VECTOR(32'h0), .RAS_DEPTH(4), .C_EXT(0)) u0 (
    .clk(clk), .reset_n(reset_n), .enable(b0.enable), .FlushTrap(b0.FlushTrap),
    .TrapVector(b0.TrapVector), .PCSrcE(b0.PCSrcE), .PCTargetE(b0.PCTargetE),
    .JALRinstr(b0.JALRinstr), .ALUResultE(b0.ALUResultE), .CallF(b0.CallF),
    .RetF(b0.RetF), .HalfF(b0.HalfF), .PCF(b0.PCF), .PCPlus4F(b0.PCPlus4F),
    .RasHitF(b0.RasHitF), .MisalignE(b0.MisalignE)
  );

  pc_unit #(.DATA_WIDTH(W), .RESET_VECTOR(32'h0), .RAS_DEPTH(4), .C_EXT(1)) u1 (
    .clk(clk), .reset_n(reset_n), .enable(b1.enable), .FlushTrap(b1.FlushTrap),
    .TrapVector(b1.TrapVector), .PCSrcE(b1.PCSrcE), .PCTargetE(b1.PCTargetE),
    .JALRinstr(b1.JALRinstr), .ALUResultE(b1.ALUResultE), .CallF(b1.CallF),
    .RetF(b1.RetF), .HalfF(b1.HalfF), .PCF(b1.PCF), .PCPlus4F(b1.PCPlus4F),
    .RasHitF(b1.RasHitF), .MisalignE(b1.MisalignE)
  );

  typedef struct {
    string          tag;
    logic [W-1:0]   val;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic exp_push(input string tag, input logic [W-1:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check(input logic [W-1:0] obs);
    sb_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard: observed %h with no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the PC expected after the next edge, take the edge, compare.
  task automatic step_pc(input string tag, input logic [W-1:0] e, input bit unit1 = 1'b0);
    exp_push(tag, e);
    tick();
    check(unit1 ? b1.PCF : b0.PCF);
  endtask

  // sig: 0 u0.PCPlus4F, 1 u0.RasHitF, 2 u0.MisalignE, 3 u1.PCPlus4F, 4 u1.MisalignE, 5 u0.PCF
  task automatic comb_chk(input string tag, input logic [W-1:0] e, input int sig);
    exp_push(tag, e);
    #1;
    case (sig)
      0:       check(b0.PCPlus4F);
      1:       check(32'(b0.RasHitF));
      2:       check(32'(b0.MisalignE));
      3:       check(b1.PCPlus4F);
      4:       check(32'(b1.MisalignE));
      default: check(b0.PCF);
    endcase
  endtask

  task automatic idle0();
    b0.FlushTrap = 0; b0.PCSrcE = 0; b0.JALRinstr = 0;
    b0.CallF = 0; b0.RetF = 0; b0.HalfF = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] lifo [4];
    lifo[0] = 32'h414; lifo[1] = 32'h410; lifo[2] = 32'h40C; lifo[3] = 32'h408;

    reset_n = 1'b0;
    idle0();
    b0.enable = 1; b0.TrapVector = '0; b0.PCTargetE = '0; b0.ALUResultE = '0;
    b1.enable = 0; b1.FlushTrap = 0; b1.TrapVector = '0; b1.PCSrcE = 0;
    b1.PCTargetE = '0; b1.JALRinstr = 0; b1.ALUResultE = '0;
    b1.CallF = 0; b1.RetF = 0; b1.HalfF = 0;

    // Reset held across edges, then release with enable=1
    tick(); tick();
    comb_chk("reset_pcf", 32'h0, 5);
    comb_chk("reset_plus4", 32'h4, 0);
    reset_n = 1'b1;
    comb_chk("release_pcf", 32'h0, 5);
    step_pc("seq_4", 32'h4);
    step_pc("seq_8", 32'h8);
    step_pc("seq_12", 32'hC);

    // Modulo wrap of the sequential successor
    b0.PCSrcE = 1; b0.PCTargetE = 32'hFFFF_FFFC;
    step_pc("br_top", 32'hFFFF_FFFC);
    b0.PCSrcE = 0;
    comb_chk("wrap_plus4", 32'h0, 0);
    step_pc("wrap_pc", 32'h0);

    // HalfF ignored without compressed support
    b0.HalfF = 1;
    comb_chk("half_ignored", 32'h4, 0);
    step_pc("half_ignored_pc", 32'h4);
    b0.HalfF = 0;

    // Call at 0x40, return at 0x80
    b0.PCSrcE = 1; b0.PCTargetE = 32'h40;
    step_pc("br_40", 32'h40);
    b0.PCSrcE = 0; b0.CallF = 1;
    comb_chk("call_plus4", 32'h44, 0);
    step_pc("call_seq", 32'h44);
    b0.CallF = 0; b0.PCSrcE = 1; b0.PCTargetE = 32'h80;
    step_pc("br_80", 32'h80);
    b0.PCSrcE = 0; b0.RetF = 1;
    comb_chk("ret_hit", 32'h1, 1);
    step_pc("ret_pc", 32'h44);
    comb_chk("ret_empty_hit", 32'h0, 1);
    step_pc("ret_empty_pc", 32'h48);
    b0.RetF = 0;

    // Stall ignores redirects
    b0.enable = 0; b0.PCSrcE = 1; b0.PCTargetE = 32'h300;
    step_pc("stall_br", 32'h48);
    b0.PCSrcE = 0;
    step_pc("stall_seq", 32'h48);
    b0.enable = 1;

    // Trap beats everything, even while stalled, and empties the RAS
    b0.CallF = 1;
    step_pc("push_4c", 32'h4C);
    b0.CallF = 0;
    b0.FlushTrap = 1; b0.TrapVector = 32'h100; b0.JALRinstr = 1; b0.ALUResultE = 32'h205;
    b0.PCSrcE = 1; b0.PCTargetE = 32'h300; b0.enable = 0;
    step_pc("trap_pc", 32'h100);
    idle0(); b0.enable = 1; b0.RetF = 1;
    comb_chk("trap_ras_empty", 32'h0, 1);
    step_pc("trap_then_seq", 32'h104);
    b0.RetF = 0;

    // JALR misalignment hold, alignment, and JALR over branch
    b0.JALRinstr = 1; b0.ALUResultE = 32'h203;
    comb_chk("jalr_misalign", 32'h1, 2);
    step_pc("jalr_misalign_hold", 32'h104);
    b0.ALUResultE = 32'h205;
    comb_chk("jalr_aligned", 32'h0, 2);
    step_pc("jalr_pc", 32'h204);
    b0.ALUResultE = 32'h401; b0.PCSrcE = 1; b0.PCTargetE = 32'h500;
    step_pc("jalr_over_br", 32'h400);
    b0.JALRinstr = 0; b0.PCTargetE = 32'h502;
    comb_chk("br_misalign", 32'h1, 2);
    step_pc("br_misalign_hold", 32'h400);
    b0.PCSrcE = 0;

    // Five calls into a four-entry stack, then five returns
    b0.CallF = 1;
    step_pc("call1", 32'h404);
    step_pc("call2", 32'h408);
    step_pc("call3", 32'h40C);
    step_pc("call4", 32'h410);
    step_pc("call5", 32'h414);
    b0.CallF = 0; b0.PCSrcE = 1; b0.PCTargetE = 32'h800;
    step_pc("br_800", 32'h800);
    b0.PCSrcE = 0; b0.RetF = 1;
    for (int i = 0; i < 4; i++) begin
      comb_chk($sformatf("ovf_hit%0d", i), 32'h1, 1);
      step_pc($sformatf("ovf_ret%0d", i), lifo[i]);
    end
    comb_chk("ovf_hit4", 32'h0, 1);
    step_pc("ovf_ret4", 32'h40C);
    b0.RetF = 0;

    // Simultaneous push and pop replaces the top
    b0.CallF = 1;
    step_pc("pp_push", 32'h410);
    b0.CallF = 0; b0.PCSrcE = 1; b0.PCTargetE = 32'h600;
    step_pc("br_600", 32'h600);
    b0.PCSrcE = 0; b0.CallF = 1; b0.RetF = 1;
    comb_chk("pp_hit", 32'h1, 1);
    step_pc("pp_pc", 32'h410);
    b0.CallF = 0;
    comb_chk("pp_hit2", 32'h1, 1);
    step_pc("pp_pc2", 32'h604);
    comb_chk("pp_empty", 32'h0, 1);
    step_pc("pp_seq", 32'h608);
    b0.RetF = 0;

    // Reset asserted mid-cycle with a non-empty stack and a pending call
    b0.CallF = 1;
    step_pc("pre_rst_push", 32'h60C);
    #2;
    reset_n = 1'b0;
    comb_chk("async_rst_pcf", 32'h0, 5);
    b0.CallF = 0;
    tick(); tick();
    reset_n = 1'b1;
    b0.RetF = 1;
    comb_chk("rst_ras_empty", 32'h0, 1);
    step_pc("rst_first_edge", 32'h4);
    b0.RetF = 0;

    // Compressed instance
    b1.enable = 1; b1.PCSrcE = 1; b1.PCTargetE = 32'h10;
    step_pc("c_br_10", 32'h10, 1'b1);
    b1.PCSrcE = 0; b1.HalfF = 1;
    comb_chk("c_half_plus", 32'h12, 3);
    step_pc("c_half_pc", 32'h12, 1'b1);
    b1.HalfF = 0;
    comb_chk("c_full_plus", 32'h16, 3);
    step_pc("c_full_pc", 32'h16, 1'b1);
    b1.PCSrcE = 1; b1.PCTargetE = 32'h22;
    comb_chk("c_no_misalign", 32'h0, 4);
    step_pc("c_br_22", 32'h22, 1'b1);
    b1.PCSrcE = 0;

    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected values left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
